// File: rtl/state_machine.sv
// Microsequenced instruction controller: a per-state control word selects the next 7-bit microstate.
// Optional STATE_MACHINE_MEM_WAIT_EN: states 105, 48 and 52 stall until MEM_R is high.
module state_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic       COND,
  input  logic       ST,
  input  logic       PL,
  input  logic       A,
  input  logic       IR_20,
  input  logic       MEM_R,
  input  logic [3:0] family_number,
  output logic [6:0] state
);

  typedef enum logic [6:0] {
    S_DP0      = 7'd0,
    S_DP1      = 7'd1,
    S_MUL0     = 7'd24,
    S_MUL      = 7'd26,
    S_MLA      = 7'd27,
    S_MULL0    = 7'd32,
    S_MULL1    = 7'd34,
    S_MLAL1    = 7'd35,
    S_MULL2    = 7'd36,
    S_MLAL2    = 7'd37,
    S_LS0      = 7'd40,
    S_LS_POST0 = 7'd41,
    S_LS_POST1 = 7'd42,
    S_LS_PRE   = 7'd43,
    S_LS_ADDR  = 7'd44,
    S_LDR      = 7'd48,
    S_STR      = 7'd52,
    S_BR0      = 7'd56,
    S_BR_EXE   = 7'd57,
    S_BR_LINK  = 7'd59,
    S_SWP0     = 7'd64,
    S_SWP1     = 7'd65,
    S_SWP2     = 7'd66,
    S_FETCH0   = 7'd104,
    S_FETCH1   = 7'd105,
    S_DECODE   = 7'd106
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_IR20 = 3'd1,
    SEL_A    = 3'd2,
    SEL_PL   = 3'd3,
    SEL_ST   = 3'd4
  } sel_t;

  // j is taken when the selected input is 1 (or unconditionally), n when it is 0
  typedef struct packed {
    state_t j;
    state_t n;
    sel_t   sel;
    logic   dec;
    logic   evcond;
    logic   memw;
  } cw_t;

  function automatic cw_t control_word(input state_t a);
    cw_t cw;
    cw = '{j: S_FETCH0, n: S_FETCH0, sel: SEL_NONE, dec: 1'b0, evcond: 1'b0, memw: 1'b0};
    case (a)
      S_FETCH0:   cw.j = S_FETCH1;
      S_FETCH1:   begin cw.j = S_DECODE; cw.memw = 1'b1; end
      S_DECODE:   begin cw.dec = 1'b1; cw.evcond = 1'b1; end
      S_DP0:      begin cw.sel = SEL_IR20; cw.j = S_DP1; cw.n = S_FETCH0; end
      S_DP1:      cw.j = S_FETCH0;
      S_MUL0:     begin cw.sel = SEL_A; cw.j = S_MLA; cw.n = S_MUL; end
      S_MUL:      cw.j = S_FETCH0;
      S_MLA:      cw.j = S_FETCH0;
      S_MULL0:    begin cw.sel = SEL_A; cw.j = S_MLAL1; cw.n = S_MULL1; end
      S_MULL1:    cw.j = S_MULL2;
      S_MLAL1:    cw.j = S_MLAL2;
      S_MULL2:    cw.j = S_FETCH0;
      S_MLAL2:    cw.j = S_FETCH0;
      S_LS0:      begin cw.sel = SEL_PL; cw.j = S_LS_PRE; cw.n = S_LS_POST0; end
      S_LS_POST0: cw.j = S_LS_POST1;
      S_LS_POST1: cw.j = S_LS_ADDR;
      S_LS_PRE:   cw.j = S_LS_ADDR;
      S_LS_ADDR:  begin cw.sel = SEL_ST; cw.j = S_STR; cw.n = S_LDR; end
      S_LDR:      begin cw.j = S_FETCH0; cw.memw = 1'b1; end
      S_STR:      begin cw.j = S_FETCH0; cw.memw = 1'b1; end
      S_BR0:      begin cw.sel = SEL_PL; cw.j = S_BR_LINK; cw.n = S_BR_EXE; end
      S_BR_LINK:  cw.j = S_BR_EXE;
      S_BR_EXE:   cw.j = S_FETCH0;
      S_SWP0:     cw.j = S_SWP1;
      S_SWP1:     cw.j = S_SWP2;
      S_SWP2:     cw.j = S_FETCH0;
      default:    cw.j = S_FETCH0;
    endcase
    return cw;
  endfunction

  function automatic state_t decode_target(input logic [3:0] fam);
    state_t t;
    case (fam)
      4'd0, 4'd1, 4'd2:          t = S_DP0;
      4'd3:                      t = S_MUL0;
      4'd4:                      t = S_MULL0;
      4'd8, 4'd9, 4'd10, 4'd11:  t = S_LS0;
      4'd12:                     t = S_SWP0;
      4'd14, 4'd15:              t = S_BR0;
      default:                   t = S_FETCH0;
    endcase
    return t;
  endfunction

  state_t address = S_FETCH0;
  state_t next_state_address;
  state_t w_branch;
  cw_t    w_cw;

  assign w_cw  = control_word(address);
  assign state = address;

  // branch resolution: only the input named by the current control word is looked at
  always_comb begin
    w_branch = w_cw.j;
    if (w_cw.dec) begin
      if (w_cw.evcond && !COND) w_branch = S_FETCH0;
      else                      w_branch = decode_target(family_number);
    end else begin
      case (w_cw.sel)
        SEL_IR20: w_branch = IR_20 ? w_cw.j : w_cw.n;
        SEL_A:    w_branch = A     ? w_cw.j : w_cw.n;
        SEL_PL:   w_branch = PL    ? w_cw.j : w_cw.n;
        SEL_ST:   w_branch = ST    ? w_cw.j : w_cw.n;
        default:  w_branch = w_cw.j;
      endcase
    end
  end

`ifdef STATE_MACHINE_MEM_WAIT_EN
  // memory-access states stall until the access completes
  always_comb begin
    next_state_address = w_branch;
    if (w_cw.memw && !MEM_R) next_state_address = address;
    else                     next_state_address = w_branch;
  end
`else
  logic w_unused;
  assign w_unused = MEM_R ^ w_cw.memw;

  // without memory waits every state advances each cycle
  always_comb begin
    next_state_address = w_branch;
  end
`endif

  // microstate register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) address <= S_FETCH0;
    else     address <= next_state_address;
  end

endmodule

// File: tb/tb_state_machine.sv
// Scoreboard bench for state_machine: stimulus queues expected microstates, a negedge monitor checks them.
module tb_state_machine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       COND = 1'b1;
  logic       ST = 1'b0;
  logic       PL = 1'b0;
  logic       A = 1'b0;
  logic       IR_20 = 1'b0;
  logic       MEM_R = 1'b1;
  logic [3:0] family_number = 4'd0;
  logic [6:0] state;

  typedef logic [6:0] st7_t;
  st7_t exp_q[$];
  st7_t seq_q[$];
  int   errors = 0;
  int   checks = 0;

  state_machine dut (
    .clk(clk), .rst(rst), .COND(COND), .ST(ST), .PL(PL), .A(A),
    .IR_20(IR_20), .MEM_R(MEM_R), .family_number(family_number), .state(state)
  );

  always #5 clk = ~clk;

  // monitor: one expected state per falling edge while the scoreboard is non-empty
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      st7_t e;
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL seq_state t=%0t fam=%0d: got %0d expected %0d", $time, family_number, state, e);
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start(input logic [3:0] fam, input logic cond, input logic pl, input logic st,
                       input logic a, input logic ir20, input logic mem_r);
    @(posedge clk);
    #2;
    rst = 1'b1;
    family_number = fam; COND = cond; PL = pl; ST = st; A = a; IR_20 = ir20; MEM_R = mem_r;
    @(posedge clk);
    #2;
    rst = 1'b0;
    foreach (seq_q[i]) exp_q.push_back(seq_q[i]);
  endtask

  task automatic run(input logic [3:0] fam, input logic cond, input logic pl, input logic st,
                     input logic a, input logic ir20);
    start(fam, cond, pl, st, a, ir20, 1'b1);
    drain();
  endtask

  task automatic direct(input string name, input st7_t exp);
    checks++;
    if (state !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, state, exp);
    end
  endtask

  initial begin
    #1;
    direct("power_up", 7'd104);

    seq_q = '{7'd104, 7'd105, 7'd106, 7'd0, 7'd104};
    run(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd0, 7'd1, 7'd104};
    run(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd0, 7'd104};
    run(4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    seq_q = '{7'd104, 7'd105, 7'd106, 7'd24, 7'd26, 7'd104};
    run(4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd24, 7'd27, 7'd104};
    run(4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd32, 7'd34, 7'd36, 7'd104};
    run(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd32, 7'd35, 7'd37, 7'd104};
    run(4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    seq_q = '{7'd104, 7'd105, 7'd106, 7'd40, 7'd41, 7'd42, 7'd44, 7'd48, 7'd104};
    run(4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd40, 7'd43, 7'd44, 7'd48, 7'd104};
    run(4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd40, 7'd41, 7'd42, 7'd44, 7'd52, 7'd104};
    run(4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd40, 7'd43, 7'd44, 7'd52, 7'd104};
    run(4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    seq_q = '{7'd104, 7'd105, 7'd106, 7'd56, 7'd57, 7'd104};
    run(4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd56, 7'd59, 7'd57, 7'd104};
    run(4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd64, 7'd65, 7'd66, 7'd104};
    run(4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    seq_q = '{7'd104, 7'd105, 7'd106, 7'd104, 7'd105};
    run(4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd104};
    run(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd104};
    run(4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a load/store
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd40, 7'd41, 7'd42};
    run(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    direct("async_reset_mid", 7'd104);
    @(negedge clk);
    #1;
    direct("reset_held", 7'd104);
    rst = 1'b0;

`ifdef STATE_MACHINE_MEM_WAIT_EN
    seq_q = '{7'd104, 7'd105, 7'd105, 7'd105, 7'd106, 7'd0, 7'd104};
    start(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    MEM_R = 1'b1;
    drain();
`else
    seq_q = '{7'd104, 7'd105, 7'd106, 7'd40, 7'd41, 7'd42, 7'd44, 7'd48, 7'd104};
    start(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
